// File: rtl/cmd_fetch_if.sv
// Bus between the command fetch stage, the command memory and the matrix unit.
// The master side is the fetch stage; the slave side is memory + matrix unit.
interface cmd_fetch_if;
  logic        start;
  logic [31:0] addr1;
  logic [31:0] read0;
  logic [31:0] addr2;
  logic [31:0] read1;
  logic [31:0] read2;
  logic [31:0] read3;
  logic [31:0] read4;
  logic        mode_valid;
  logic [1:0]  mode_value;
  logic        row_valid;
  logic        row_ready;
  logic [31:0] row_data0;
  logic [31:0] row_data1;
  logic [31:0] row_data2;
  logic [31:0] row_data3;
  logic [1:0]  row_idx;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    input  start, read0, read1, read2, read3, read4, row_ready,
    output addr1, addr2, mode_valid, mode_value, row_valid,
           row_data0, row_data1, row_data2, row_data3, row_idx,
           busy, done, error
  );

  modport slave (
    output start, read0, read1, read2, read3, read4, row_ready,
    input  addr1, addr2, mode_valid, mode_value, row_valid,
           row_data0, row_data1, row_data2, row_data3, row_idx,
           busy, done, error
  );
endinterface

// File: rtl/cmd_fetch.sv
// Command-stream fetch/decode stage. Walks a combinational-read command memory,
// decodes MATRIX_MODE / LOAD_MATRIX / END and streams 4x4 matrix payload rows
// to the matrix unit over a valid/ready handshake.
module cmd_fetch #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned MAX_CMDS  = 256
) (
  input logic         clk,
  input logic         rst,
  cmd_fetch_if.master bus
);
  localparam logic [31:0] BASE    = {BASE_ADDR[31:2], 2'b00};
  localparam logic [31:0] MAX_CNT = MAX_CMDS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_LOAD,
    S_SEND,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] ptr;
  logic [31:0] cmd;
  logic [31:0] cmd_cnt;
  logic        is_end;
  logic        is_mode;
  logic        is_load;
  logic        wd_trip;
  logic        cmd_unused;

  // Opcode decode of the latched command word.
  assign is_end  = (cmd[7:0] == 8'h00);
  assign is_mode = (cmd[7:0] == 8'h10);
  assign is_load = (cmd[7:0] == 8'h13) && cmd[31] && (cmd[15:8] == 8'h10);
  assign wd_trip = (cmd_cnt >= MAX_CNT);
  // Reserved command bits carry no meaning for any supported opcode.
  assign cmd_unused = ^cmd[30:16];

  assign bus.addr1 = pc;
  assign bus.addr2 = ptr;
  assign bus.busy  = (state == S_FETCH) || (state == S_DECODE) ||
                     (state == S_LOAD)  || (state == S_SEND);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; END is checked before the watchdog so it is never counted.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (bus.start) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        if (is_end)       state_nxt = S_DONE;
        else if (wd_trip) state_nxt = S_ERROR;
        else if (is_mode) state_nxt = S_FETCH;
        else if (is_load) state_nxt = S_LOAD;
        else              state_nxt = S_ERROR;
      end
      S_LOAD:   state_nxt = S_SEND;
      S_SEND: begin
        if (bus.row_ready) state_nxt = (bus.row_idx == 2'd3) ? S_FETCH : S_LOAD;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Command word capture; only consumed in DECODE, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state == S_FETCH) cmd <= bus.read0;
  end

  // Pointers, counters, status flags and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc             <= BASE;
      ptr            <= BASE;
      cmd_cnt        <= '0;
      bus.mode_valid <= 1'b0;
      bus.mode_value <= '0;
      bus.row_valid  <= 1'b0;
      bus.row_data0  <= '0;
      bus.row_data1  <= '0;
      bus.row_data2  <= '0;
      bus.row_data3  <= '0;
      bus.row_idx    <= '0;
      bus.done       <= 1'b0;
      bus.error      <= 1'b0;
    end else begin
      bus.mode_valid <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (bus.start) begin
            pc        <= BASE;
            cmd_cnt   <= '0;
            bus.done  <= 1'b0;
            bus.error <= 1'b0;
          end
        end
        S_FETCH: pc <= pc + 32'd4;
        S_DECODE: begin
          if (state_nxt == S_DONE)  bus.done  <= 1'b1;
          if (state_nxt == S_ERROR) bus.error <= 1'b1;
          if (!is_end && !wd_trip && is_mode) begin
            bus.mode_value <= cmd[9:8];
            bus.mode_valid <= 1'b1;
            cmd_cnt        <= cmd_cnt + 32'd1;
          end
          if (!is_end && !wd_trip && !is_mode && is_load) begin
            ptr         <= pc;
            bus.row_idx <= 2'd0;
            cmd_cnt     <= cmd_cnt + 32'd1;
          end
        end
        S_LOAD: begin
          bus.row_data0 <= bus.read1;
          bus.row_data1 <= bus.read2;
          bus.row_data2 <= bus.read3;
          bus.row_data3 <= bus.read4;
          bus.row_valid <= 1'b1;
        end
        S_SEND: begin
          if (bus.row_ready) begin
            bus.row_valid <= 1'b0;
            ptr           <= ptr + 32'd16;
            if (bus.row_idx == 2'd3) pc <= ptr + 32'd16;
            else                     bus.row_idx <= bus.row_idx + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cmd_fetch.sv
// Self-checking bench for cmd_fetch: a shared command memory, a stream-level
// reference model and per-scenario tasks.
module tb_cmd_fetch;
  typedef struct packed {
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] d3;
    logic [1:0]  idx;
  } row_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cmd_fetch_if bus1 ();
  cmd_fetch_if bus2 ();

  cmd_fetch #(.BASE_ADDR(32'h0), .MAX_CMDS(256)) dut (
    .clk(clk), .rst(rst), .bus(bus1)
  );
  cmd_fetch #(.BASE_ADDR(32'h0), .MAX_CMDS(2)) dut_wd (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  // Command memory, combinational read, word addressed by addr[9:2].
  logic [31:0] mem [256];
  logic [31:0] a1p4, a1p8, a1p12, a2p4, a2p8, a2p12;
  assign a1p4  = bus1.addr2 + 32'd4;
  assign a1p8  = bus1.addr2 + 32'd8;
  assign a1p12 = bus1.addr2 + 32'd12;
  assign a2p4  = bus2.addr2 + 32'd4;
  assign a2p8  = bus2.addr2 + 32'd8;
  assign a2p12 = bus2.addr2 + 32'd12;
  assign bus1.read0 = mem[bus1.addr1[9:2]];
  assign bus1.read1 = mem[bus1.addr2[9:2]];
  assign bus1.read2 = mem[a1p4[9:2]];
  assign bus1.read3 = mem[a1p8[9:2]];
  assign bus1.read4 = mem[a1p12[9:2]];
  assign bus2.read0 = mem[bus2.addr1[9:2]];
  assign bus2.read1 = mem[bus2.addr2[9:2]];
  assign bus2.read2 = mem[a2p4[9:2]];
  assign bus2.read3 = mem[a2p8[9:2]];
  assign bus2.read4 = mem[a2p12[9:2]];

  int tests_run = 0;
  int fails = 0;

  // Observation (written only by the monitors).
  row_t        obs_rows[$];
  logic [1:0]  obs_modes[$];
  logic [1:0]  obs_modes2[$];
  int          stab_viol = 0;
  int          rowv_seen = 0;
  int          rowv_seen2 = 0;
  logic        last_v = 1'b0;
  logic        last_r = 1'b0;
  row_t        last_row;
  row_t        cur1;
  assign cur1 = {bus1.row_data0, bus1.row_data1, bus1.row_data2, bus1.row_data3, bus1.row_idx};

  // Expectations from the model.
  row_t        exp_rows[$];
  logic [1:0]  exp_modes[$];

  // Monitor for the main DUT: handshakes, mode pulses, hold-while-stalled.
  always @(negedge clk) begin
    if (rst) begin
      last_v = 1'b0;
      last_r = 1'b0;
    end else begin
      if (last_v && !last_r && (!bus1.row_valid || cur1 != last_row)) stab_viol++;
      if (bus1.mode_valid) obs_modes.push_back(bus1.mode_value);
      if (bus1.row_valid && bus1.row_ready) obs_rows.push_back(cur1);
      if (bus1.row_valid) rowv_seen++;
      last_v   = bus1.row_valid;
      last_r   = bus1.row_ready;
      last_row = cur1;
    end
  end

  // Monitor for the watchdog DUT.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus2.mode_valid) obs_modes2.push_back(bus2.mode_value);
      if (bus2.row_valid) rowv_seen2++;
    end
  end

  initial begin
    #900_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // Stream-level reference: walk the command list and list what must come out.
  task automatic model(input int unsigned maxc, output bit edone, output logic [31:0] epc);
    logic [31:0] pc;
    logic [31:0] w;
    logic [31:0] a;
    int unsigned cnt;
    row_t r;
    pc = 32'h0;
    cnt = 0;
    edone = 1'b0;
    epc = 32'h0;
    exp_modes.delete();
    exp_rows.delete();
    for (int guard = 0; guard < 1000; guard++) begin
      w = mem[pc[9:2]];
      pc = pc + 32'd4;
      if (w[7:0] == 8'h00) begin
        edone = 1'b1;
        epc = pc;
        return;
      end
      if (cnt >= maxc) return;
      if (w[7:0] == 8'h10) begin
        exp_modes.push_back(w[9:8]);
        cnt++;
      end else if (w[7:0] == 8'h13 && w[31] && w[15:8] == 8'h10) begin
        cnt++;
        for (int k = 0; k < 4; k++) begin
          a = pc;
          r.d0 = mem[a[9:2]]; a = a + 32'd4;
          r.d1 = mem[a[9:2]]; a = a + 32'd4;
          r.d2 = mem[a[9:2]]; a = a + 32'd4;
          r.d3 = mem[a[9:2]];
          r.idx = 2'(k);
          exp_rows.push_back(r);
          pc = pc + 32'd16;
        end
      end else begin
        return;
      end
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask

  task automatic load_stream();
    clear_mem();
    mem[0] = 32'h0000_0010;
    mem[1] = 32'h0000_0110;
    mem[2] = 32'h8000_1013;
    mem[3] = 32'h4201_3333;
    mem[4] = 32'h42C8_A666;
    mem[5] = 32'h44A7_2000;
    mem[6] = 32'h3F80_0000;
    for (int i = 7; i < 19; i++) mem[i] = 32'h4000_0000 + 32'(i) * 32'h111;
    mem[19] = 32'h0000_0000;
  endtask

  task automatic pulse_start1();
    @(posedge clk); #1 bus1.start = 1'b1;
    @(posedge clk); #1 bus1.start = 1'b0;
  endtask

  // Run the main DUT until done/error; policy 0 ready=1, 1 random, 2 stall 5 cycles per row.
  task automatic run1(input int policy, input int budget, input string name);
    int cyc;
    int waitc;
    cyc = 0;
    waitc = 0;
    while (!(bus1.done || bus1.error) && cyc < budget) begin
      case (policy)
        0: bus1.row_ready = 1'b1;
        1: bus1.row_ready = 1'($urandom_range(0, 1));
        default: begin
          if (!bus1.row_valid) begin
            waitc = 0;
            bus1.row_ready = 1'b0;
          end else if (waitc < 5) begin
            waitc++;
            bus1.row_ready = 1'b0;
          end else begin
            bus1.row_ready = 1'b1;
          end
        end
      endcase
      @(posedge clk); #1;
      cyc++;
    end
    tests_run++;
    if (!(bus1.done || bus1.error)) begin
      fails++;
      $display("FAIL %s_timeout: done/error still low after %0d cycles", name, budget);
    end
    bus1.row_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus1.start = 1'b0;
    bus1.row_ready = 1'b0;
    bus2.start = 1'b0;
    bus2.row_ready = 1'b1;
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({bus1.mode_valid, bus1.mode_value, bus1.row_valid, bus1.row_idx, bus1.busy, bus1.done, bus1.error} !== 9'h0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b want 0", {bus1.mode_valid, bus1.mode_value, bus1.row_valid, bus1.row_idx, bus1.busy, bus1.done, bus1.error});
    end
    tests_run++;
    if ((bus1.row_data0 | bus1.row_data1 | bus1.row_data2 | bus1.row_data3) !== 32'h0) begin
      fails++;
      $display("FAIL reset_rowdata: got %h %h %h %h want 0", bus1.row_data0, bus1.row_data1, bus1.row_data2, bus1.row_data3);
    end
    tests_run++;
    if ({bus1.addr1, bus1.addr2} !== 64'h0) begin
      fails++;
      $display("FAIL reset_addr: addr1=%h addr2=%h want 0", bus1.addr1, bus1.addr2);
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({bus1.busy, bus1.done, bus1.error, bus2.busy, bus2.error} !== 5'b0) begin
      fails++;
      $display("FAIL reset_idle: busy/done/error=%b want 0", {bus1.busy, bus1.done, bus1.error, bus2.busy, bus2.error});
    end
  endtask

  task automatic test_stream();
    bit edone;
    logic [31:0] epc;
    int m0, r0;
    load_stream();
    model(256, edone, epc);
    m0 = obs_modes.size();
    r0 = obs_rows.size();
    pulse_start1();
    tests_run++;
    if (bus1.addr1 !== 32'h0 || bus1.busy !== 1'b1) begin
      fails++;
      $display("FAIL stream_first_fetch: addr1=%h busy=%b want 0/1", bus1.addr1, bus1.busy);
    end
    run1(0, 500, "stream");
    tests_run++;
    if (obs_modes.size() - m0 != 2 || obs_modes[m0] !== 2'd0 || obs_modes[m0+1] !== 2'd1) begin
      fails++;
      $display("FAIL stream_modes: got %0d pulses want modes 0,1", obs_modes.size() - m0);
    end
    tests_run++;
    if (obs_rows.size() - r0 != exp_rows.size()) begin
      fails++;
      $display("FAIL stream_rowcount: got %0d want %0d", obs_rows.size() - r0, exp_rows.size());
    end else begin
      for (int k = 0; k < exp_rows.size(); k++) begin
        tests_run++;
        if (obs_rows[r0+k] !== exp_rows[k]) begin
          fails++;
          $display("FAIL stream_row%0d: got %h want %h", k, obs_rows[r0+k], exp_rows[k]);
        end
      end
      tests_run++;
      if (obs_rows[r0] !== {32'h4201_3333, 32'h42C8_A666, 32'h44A7_2000, 32'h3F80_0000, 2'd0}) begin
        fails++;
        $display("FAIL stream_row0_const: got %h", obs_rows[r0]);
      end
    end
    tests_run++;
    if (bus1.done !== 1'b1 || bus1.error !== 1'b0 || bus1.addr1 !== 32'h50) begin
      fails++;
      $display("FAIL stream_end: done=%b error=%b addr1=%h want 1/0/00000050", bus1.done, bus1.error, bus1.addr1);
    end
  endtask

  task automatic test_back_pressure();
    bit edone;
    logic [31:0] epc;
    int r0, s0;
    load_stream();
    model(256, edone, epc);
    r0 = obs_rows.size();
    s0 = stab_viol;
    pulse_start1();
    run1(2, 1000, "backpressure");
    tests_run++;
    if (stab_viol != s0) begin
      fails++;
      $display("FAIL bp_stable: %0d cycles changed while stalled, want 0", stab_viol - s0);
    end
    tests_run++;
    if (obs_rows.size() - r0 != 4) begin
      fails++;
      $display("FAIL bp_handshakes: got %0d want 4", obs_rows.size() - r0);
    end else begin
      for (int k = 0; k < 4; k++) begin
        tests_run++;
        if (obs_rows[r0+k] !== exp_rows[k]) begin
          fails++;
          $display("FAIL bp_row%0d: got %h want %h", k, obs_rows[r0+k], exp_rows[k]);
        end
      end
    end
    tests_run++;
    if (bus1.done !== 1'b1) begin
      fails++;
      $display("FAIL bp_done: got %b want 1", bus1.done);
    end
  endtask

  task automatic test_bad_opcode();
    int m0, v0;
    clear_mem();
    mem[0] = 32'h0000_0017;
    m0 = obs_modes.size();
    v0 = rowv_seen;
    pulse_start1();
    run1(0, 50, "badop");
    tests_run++;
    if (bus1.error !== 1'b1 || bus1.done !== 1'b0) begin
      fails++;
      $display("FAIL badop_flags: error=%b done=%b want 1/0", bus1.error, bus1.done);
    end
    tests_run++;
    if (obs_modes.size() != m0 || rowv_seen != v0) begin
      fails++;
      $display("FAIL badop_quiet: modes=%0d rowv=%0d want 0/0", obs_modes.size() - m0, rowv_seen - v0);
    end
    pulse_start1();
    tests_run++;
    if (bus1.error !== 1'b0 || bus1.busy !== 1'b1 || bus1.addr1 !== 32'h0) begin
      fails++;
      $display("FAIL badop_restart: error=%b busy=%b addr1=%h want 0/1/0", bus1.error, bus1.busy, bus1.addr1);
    end
    run1(0, 50, "badop2");
  endtask

  task automatic test_bad_count();
    logic [31:0] bad [2];
    int v0;
    bad[0] = 32'h8000_0813;
    bad[1] = 32'h0000_1013;
    for (int i = 0; i < 2; i++) begin
      clear_mem();
      mem[0] = bad[i];
      for (int j = 1; j < 18; j++) mem[j] = 32'hA5A5_0000 + 32'(j);
      v0 = rowv_seen;
      pulse_start1();
      run1(0, 50, "badcount");
      tests_run++;
      if (bus1.error !== 1'b1 || rowv_seen != v0) begin
        fails++;
        $display("FAIL badcount_%0d: error=%b rowv=%0d want 1/0", i, bus1.error, rowv_seen - v0);
      end
    end
  endtask

  task automatic test_rst_mid_transfer();
    bit edone;
    logic [31:0] epc;
    int cyc, r0;
    load_stream();
    model(256, edone, epc);
    pulse_start1();
    cyc = 0;
    bus1.row_ready = 1'b1;
    while (!(bus1.row_valid && bus1.row_idx == 2'd2) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    bus1.row_ready = 1'b0;
    tests_run++;
    if (!(bus1.row_valid && bus1.row_idx == 2'd2)) begin
      fails++;
      $display("FAIL rstmid_reach: row_valid=%b row_idx=%0d want 1/2", bus1.row_valid, bus1.row_idx);
    end
    #3 rst = 1'b1;
    #1;
    tests_run++;
    if ({bus1.row_valid, bus1.row_idx, bus1.busy, bus1.done, bus1.error, bus1.mode_valid} !== 7'h0 ||
        bus1.row_data0 !== 32'h0 || bus1.addr1 !== 32'h0) begin
      fails++;
      $display("FAIL rstmid_outputs: rv=%b idx=%0d busy=%b d0=%h addr1=%h want 0",
               bus1.row_valid, bus1.row_idx, bus1.busy, bus1.row_data0, bus1.addr1);
    end
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    r0 = obs_rows.size();
    pulse_start1();
    run1(1, 1000, "rstmid");
    tests_run++;
    if (obs_rows.size() - r0 != 4 || bus1.done !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_restart: rows=%0d done=%b want 4/1", obs_rows.size() - r0, bus1.done);
    end else begin
      for (int k = 0; k < 4; k++) begin
        tests_run++;
        if (obs_rows[r0+k] !== exp_rows[k]) begin
          fails++;
          $display("FAIL rstmid_row%0d: got %h want %h", k, obs_rows[r0+k], exp_rows[k]);
        end
      end
    end
  endtask

  task automatic test_watchdog();
    bit edone;
    logic [31:0] epc;
    int cyc, m0;
    clear_mem();
    mem[0] = 32'h0000_0110;
    mem[1] = 32'h0000_0210;
    mem[2] = 32'h0000_0310;
    model(2, edone, epc);
    m0 = obs_modes2.size();
    @(posedge clk); #1 bus2.start = 1'b1;
    @(posedge clk); #1 bus2.start = 1'b0;
    cyc = 0;
    while (!(bus2.done || bus2.error) && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    tests_run++;
    if (bus2.error !== 1'b1 || bus2.done !== 1'b0 || edone) begin
      fails++;
      $display("FAIL wd_flags: error=%b done=%b want 1/0", bus2.error, bus2.done);
    end
    tests_run++;
    if (obs_modes2.size() - m0 != exp_modes.size() || exp_modes.size() != 2) begin
      fails++;
      $display("FAIL wd_pulses: got %0d want 2", obs_modes2.size() - m0);
    end else if (obs_modes2[m0] !== exp_modes[0] || obs_modes2[m0+1] !== exp_modes[1]) begin
      fails++;
      $display("FAIL wd_values: got %0d,%0d want %0d,%0d", obs_modes2[m0], obs_modes2[m0+1], exp_modes[0], exp_modes[1]);
    end
  endtask

  task automatic test_random();
    bit edone;
    logic [31:0] epc;
    int w, ncmd, kind, m0, r0, s0;
    for (int it = 0; it < 20; it++) begin
      clear_mem();
      w = 0;
      ncmd = $urandom_range(1, 6);
      for (int c = 0; c < ncmd; c++) begin
        kind = $urandom_range(0, 9);
        if (kind < 5) begin
          mem[w] = ($urandom & 32'h7FFF_FF00) | 32'h10;
          w++;
        end else if (kind < 9) begin
          mem[w] = 32'h8000_1013 | ($urandom & 32'h7FFF_0000);
          w++;
          for (int p = 0; p < 16; p++) begin
            mem[w] = $urandom;
            w++;
          end
        end else begin
          case ($urandom_range(0, 2))
            0: mem[w] = 32'h8000_0813;
            1: mem[w] = 32'h0000_1013;
            default: mem[w] = 32'h20 + 32'($urandom_range(0, 200));
          endcase
          w++;
        end
      end
      mem[w] = 32'h0;
      model(256, edone, epc);
      m0 = obs_modes.size();
      r0 = obs_rows.size();
      s0 = stab_viol;
      pulse_start1();
      run1(it % 3, 2000, "random");
      tests_run++;
      if (bus1.done !== edone || bus1.error !== !edone || (edone && bus1.addr1 !== epc)) begin
        fails++;
        $display("FAIL rand%0d_end: done=%b error=%b addr1=%h want done=%b pc=%h", it, bus1.done, bus1.error, bus1.addr1, edone, epc);
      end
      tests_run++;
      if (obs_modes.size() - m0 != exp_modes.size() || obs_rows.size() - r0 != exp_rows.size() || stab_viol != s0) begin
        fails++;
        $display("FAIL rand%0d_counts: modes=%0d rows=%0d unstable=%0d want %0d/%0d/0", it,
                 obs_modes.size() - m0, obs_rows.size() - r0, stab_viol - s0, exp_modes.size(), exp_rows.size());
      end else begin
        for (int k = 0; k < exp_modes.size(); k++) begin
          tests_run++;
          if (obs_modes[m0+k] !== exp_modes[k]) begin
            fails++;
            $display("FAIL rand%0d_mode%0d: got %0d want %0d", it, k, obs_modes[m0+k], exp_modes[k]);
          end
        end
        for (int k = 0; k < exp_rows.size(); k++) begin
          tests_run++;
          if (obs_rows[r0+k] !== exp_rows[k]) begin
            fails++;
            $display("FAIL rand%0d_row%0d: got %h want %h", it, k, obs_rows[r0+k], exp_rows[k]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_pressure();
    test_bad_opcode();
    test_bad_count();
    test_rst_mid_transfer();
    test_watchdog();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
